mips_cpu_bus_bridge: RTL and testbench

Memory-side neighbour of the Harvard core: converts the core's combinational instruction port and combinational-read/single-cycle-write data port into one shared Avalon-style memory-mapped bus with `waitrequest`. It sequences fetch, optional data access and commit, and gates the core through `core_clk_enable` so the core advances exactly one instruction per commit cycle regardless of bus wait states.

---
 rtl/mips_cpu_bus_bridge_if.sv | 21 ++
 rtl/mips_cpu_bus_bridge.sv | 196 +++++++++++++++++++
 tb/tb_mips_cpu_bus_bridge.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/mips_cpu_bus_bridge_if.sv
// Shared Avalon-style memory-mapped bus between the core bridge and memory.
// The master drives the request side; the slave answers with waitrequest/readdata.
interface mips_cpu_bus_bridge_if;
   logic [31:0] address;
   logic        read;
   logic        write;
   logic [31:0] writedata;
   logic [3:0]  byteenable;
   logic        waitrequest;
   logic [31:0] readdata;

   modport master (
      output address, read, write, writedata, byteenable,
      input  waitrequest, readdata
   );

   modport slave (
      input  address, read, write, writedata, byteenable,
      output waitrequest, readdata
   );
endinterface

// File: rtl/mips_cpu_bus_bridge.sv
// Bridge between the Harvard core's instruction/data ports and one shared
// memory bus. Each instruction is sequenced as FETCH -> DATA -> COMMIT, and
// the core is clocked forward by a single core_clk_enable pulse in COMMIT,
// so bus wait states never reach the core.
module mips_cpu_bus_bridge #(
   parameter int unsigned STALL_LIMIT = 0
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         core_active,
   input  logic [31:0]                  core_instr_address,
   output logic [31:0]                  core_instr_readdata,
   input  logic [31:0]                  core_data_address,
   input  logic                         core_data_read,
   input  logic                         core_data_write,
   input  logic [31:0]                  core_data_writedata,
   output logic [31:0]                  core_data_readdata,
   output logic                         core_clk_enable,
   mips_cpu_bus_bridge_if.master        bus,
   output logic                         active,
   output logic                         bus_error
);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      FETCH  = 3'd1,
      DATA   = 3'd2,
      COMMIT = 3'd3,
      HALT   = 3'd4
   } state_t;

   state_t      state_r;
   state_t      state_next_s;
   logic [31:0] instr_r;
   logic [31:0] load_r;
   logic [31:0] stall_cnt_r;
   logic [31:0] stall_cnt_next_s;
   logic [32:0] stall_cnt_inc_s;
   logic        bus_error_r;

   logic        req_rd_s;
   logic        req_wr_s;
   logic        req_s;
   logic [31:0] addr_s;
   logic        timeout_s;
   logic        ir_load_s;
   logic        lr_load_s;
   logic        err_set_s;

   // Bus addresses are always word aligned; the byte offset is dropped.
   function automatic logic [31:0] word_align(input logic [31:0] a);
      return a & 32'hFFFF_FFFC;
   endfunction

   // Request decode: purely from the state register and the (frozen) core
   // outputs, so requests hold steady across wait states and vanish the
   // cycle after reset returns the machine to IDLE.
   always_comb begin
      req_rd_s = 1'b0;
      req_wr_s = 1'b0;
      addr_s   = 32'h0000_0000;
      case (state_r)
         FETCH: begin
            req_rd_s = 1'b1;
            addr_s   = word_align(core_instr_address);
         end
         DATA: begin
            if (core_data_write) begin
               // A store wins when the core raises both strobes.
               req_wr_s = 1'b1;
               addr_s   = word_align(core_data_address);
            end else if (core_data_read) begin
               req_rd_s = 1'b1;
               addr_s   = word_align(core_data_address);
            end else begin
               addr_s   = 32'h0000_0000;
            end
         end
         default: begin
            req_rd_s = 1'b0;
            req_wr_s = 1'b0;
         end
      endcase
   end

   assign req_s = req_rd_s | req_wr_s;

   // Stall watchdog: counts wait cycles of the current transfer, saturating,
   // and flags a timeout on the wait cycle that reaches STALL_LIMIT.
   always_comb begin
      stall_cnt_inc_s  = {1'b0, stall_cnt_r} + 33'd1;
      stall_cnt_next_s = 32'h0000_0000;
      timeout_s        = 1'b0;
      if (req_s && bus.waitrequest) begin
         if (stall_cnt_r != 32'hFFFF_FFFF) begin
            stall_cnt_next_s = stall_cnt_inc_s[31:0];
         end else begin
            stall_cnt_next_s = stall_cnt_r;
         end
         if ((STALL_LIMIT != 32'd0) && (stall_cnt_inc_s >= 33'(STALL_LIMIT))) begin
            timeout_s = 1'b1;
         end else begin
            timeout_s = 1'b0;
         end
      end else begin
         stall_cnt_next_s = 32'h0000_0000;
         timeout_s        = 1'b0;
      end
   end

   // Next-state logic plus the capture strobes for the two latched words.
   always_comb begin
      state_next_s = state_r;
      ir_load_s    = 1'b0;
      lr_load_s    = 1'b0;
      err_set_s    = 1'b0;
      case (state_r)
         IDLE: begin
            state_next_s = FETCH;
         end
         FETCH: begin
            if (timeout_s) begin
               err_set_s    = 1'b1;
               state_next_s = HALT;
            end else if (!bus.waitrequest) begin
               ir_load_s    = 1'b1;
               state_next_s = DATA;
            end else begin
               state_next_s = FETCH;
            end
         end
         DATA: begin
            if (!req_s) begin
               // Core decoded a non-memory instruction: evaluate-only cycle.
               state_next_s = COMMIT;
            end else if (timeout_s) begin
               err_set_s    = 1'b1;
               state_next_s = HALT;
            end else if (!bus.waitrequest) begin
               lr_load_s    = req_rd_s;
               state_next_s = COMMIT;
            end else begin
               state_next_s = DATA;
            end
         end
         COMMIT: begin
            if (core_active) begin
               state_next_s = FETCH;
            end else begin
               state_next_s = HALT;
            end
         end
         HALT: begin
            state_next_s = HALT;
         end
         default: begin
            state_next_s = IDLE;
         end
      endcase
   end

   // State, latched instruction/load words, stall counter and sticky error.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r     <= IDLE;
         instr_r     <= 32'h0000_0000;
         load_r      <= 32'h0000_0000;
         stall_cnt_r <= 32'h0000_0000;
         bus_error_r <= 1'b0;
      end else begin
         state_r     <= state_next_s;
         stall_cnt_r <= stall_cnt_next_s;
         if (ir_load_s) begin
            instr_r <= bus.readdata;
         end
         if (lr_load_s) begin
            load_r <= bus.readdata;
         end
         if (err_set_s) begin
            bus_error_r <= 1'b1;
         end
      end
   end

   assign bus.read            = req_rd_s;
   assign bus.write           = req_wr_s;
   assign bus.address         = addr_s;
   assign bus.writedata       = core_data_writedata;
   assign bus.byteenable      = 4'hF;
   assign core_instr_readdata = instr_r;
   assign core_data_readdata  = load_r;
   assign core_clk_enable     = (state_r == COMMIT);
   assign active              = (state_r != HALT);
   assign bus_error           = bus_error_r;

endmodule

// File: tb/tb_mips_cpu_bus_bridge.sv
// Directed bench for mips_cpu_bus_bridge: a table of instruction transactions
// checked cycle by cycle, plus hand sequences for reset and stall timeout.
module tb_mips_cpu_bus_bridge;
   logic        clk = 1'b0;
   logic        reset;
   logic        core_active;
   logic [31:0] core_instr_address;
   logic [31:0] core_instr_readdata;
   logic [31:0] core_data_address;
   logic        core_data_read;
   logic        core_data_write;
   logic [31:0] core_data_writedata;
   logic [31:0] core_data_readdata;
   logic        core_clk_enable;
   logic        active;
   logic        bus_error;

   mips_cpu_bus_bridge_if bus();

   mips_cpu_bus_bridge #(.STALL_LIMIT(4)) dut (
      .clk                 (clk),
      .reset               (reset),
      .core_active         (core_active),
      .core_instr_address  (core_instr_address),
      .core_instr_readdata (core_instr_readdata),
      .core_data_address   (core_data_address),
      .core_data_read      (core_data_read),
      .core_data_write     (core_data_write),
      .core_data_writedata (core_data_writedata),
      .core_data_readdata  (core_data_readdata),
      .core_clk_enable     (core_clk_enable),
      .bus                 (bus),
      .active              (active),
      .bus_error           (bus_error)
   );

   always #5 clk = ~clk;

   localparam logic [31:0] JUNK = 32'hA5A5_A5A5;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] instr;
      logic [31:0] daddr;
      logic [31:0] wdata;
      logic [31:0] rdata;
      logic        drd;
      logic        dwr;
      logic        act;
      int          fw;
      int          dw;
      logic [31:0] faddr_exp;
      logic [31:0] daddr_exp;
      logic [31:0] load_exp;
      logic        rd_exp;
      logic        wr_exp;
      int          cycles_exp;
   } vec_t;

   vec_t        tbl [7];
   int          n_tests = 0;
   int          n_fail  = 0;
   logic [31:0] last_instr;
   logic [31:0] last_load;

   task automatic check_cycle(input string name, input logic e_rd, input logic e_wr,
                              input logic e_cke, input logic e_act, input logic e_err,
                              input logic [31:0] e_addr, input logic [31:0] e_wdata,
                              input logic [31:0] e_ir, input logic [31:0] e_lr);
      logic [136:0] got;
      logic [136:0] want;
      got  = {bus.read, bus.write, core_clk_enable, active, bus_error, bus.byteenable,
              (e_rd | e_wr) ? bus.address : 32'h0, e_wr ? bus.writedata : 32'h0,
              core_instr_readdata, core_data_readdata};
      want = {e_rd, e_wr, e_cke, e_act, e_err, 4'hF, e_addr, e_wdata, e_ir, e_lr};
      n_tests++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s: got rd/wr/cke/act/err/be/addr/wdata/ir/lr=%h required %h", name, got, want);
      end
   endtask

   task automatic do_reset(input string name);
      reset           = 1'b1;
      bus.waitrequest = 1'b0;
      bus.readdata    = JUNK;
      @(negedge clk);
      #1;
      check_cycle(name, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
      reset      = 1'b0;
      last_instr = 32'h0;
      last_load  = 32'h0;
      @(negedge clk);
   endtask

   task automatic run_vec(input vec_t v, input int idx);
      int  n_f;
      int  k;
      logic mem;
      core_instr_address  = v.pc;
      core_data_address   = v.daddr;
      core_data_read      = v.drd;
      core_data_write     = v.dwr;
      core_data_writedata = v.wdata;
      core_active         = v.act;
      n_f = v.fw + 1;
      mem = v.rd_exp | v.wr_exp;
      for (int c = 0; c < v.cycles_exp; c++) begin
         #1;
         if (c == v.cycles_exp - 1) begin
            check_cycle($sformatf("v%0d commit c%0d", idx, c), 1'b0, 1'b0, 1'b1, 1'b1, 1'b0,
                        32'h0, 32'h0, v.instr, v.load_exp);
            bus.waitrequest = 1'b0;
            bus.readdata    = JUNK;
         end else if (c < n_f) begin
            check_cycle($sformatf("v%0d fetch c%0d", idx, c), 1'b1, 1'b0, 1'b0, 1'b1, 1'b0,
                        v.faddr_exp, 32'h0, last_instr, last_load);
            bus.waitrequest = (c < v.fw);
            bus.readdata    = (c == v.fw) ? v.instr : JUNK;
         end else begin
            k = c - n_f;
            check_cycle($sformatf("v%0d data c%0d", idx, c), v.rd_exp, v.wr_exp, 1'b0, 1'b1, 1'b0,
                        mem ? v.daddr_exp : 32'h0, v.wr_exp ? v.wdata : 32'h0, v.instr, last_load);
            bus.waitrequest = mem && (k < v.dw);
            bus.readdata    = (k == v.dw) ? v.rdata : JUNK;
         end
         @(negedge clk);
      end
      last_instr = v.instr;
      last_load  = v.load_exp;
   endtask

   initial begin
      // addiu, zero wait: FETCH, DATA-evaluate, COMMIT
      tbl[0] = '{pc:32'hBFC0_0000, instr:32'h2402_0005, daddr:32'h0, wdata:32'h0, rdata:32'h7777_7777,
                 drd:1'b0, dwr:1'b0, act:1'b1, fw:0, dw:0, faddr_exp:32'hBFC0_0000, daddr_exp:32'h0,
                 load_exp:32'h0, rd_exp:1'b0, wr_exp:1'b0, cycles_exp:3};
      // load with two data wait cycles
      tbl[1] = '{pc:32'hBFC0_0004, instr:32'h8C43_0000, daddr:32'h0000_2000, wdata:32'h0, rdata:32'hDEAD_BEEF,
                 drd:1'b1, dwr:1'b0, act:1'b1, fw:0, dw:2, faddr_exp:32'hBFC0_0004, daddr_exp:32'h0000_2000,
                 load_exp:32'hDEAD_BEEF, rd_exp:1'b1, wr_exp:1'b0, cycles_exp:5};
      // store to unaligned address: bus sees the word address
      tbl[2] = '{pc:32'hBFC0_0008, instr:32'hAC44_0000, daddr:32'h0000_1006, wdata:32'h1234_5678, rdata:32'h5555_5555,
                 drd:1'b0, dwr:1'b1, act:1'b1, fw:0, dw:0, faddr_exp:32'hBFC0_0008, daddr_exp:32'h0000_1004,
                 load_exp:32'hDEAD_BEEF, rd_exp:1'b0, wr_exp:1'b1, cycles_exp:3};
      // read and write together: only the write goes out
      tbl[3] = '{pc:32'hBFC0_000C, instr:32'hAC45_0000, daddr:32'h0000_3000, wdata:32'hCAFE_F00D, rdata:32'h1111_1111,
                 drd:1'b1, dwr:1'b1, act:1'b1, fw:0, dw:1, faddr_exp:32'hBFC0_000C, daddr_exp:32'h0000_3000,
                 load_exp:32'hDEAD_BEEF, rd_exp:1'b0, wr_exp:1'b1, cycles_exp:4};
      // fetch with STALL_LIMIT-1 waits completes, unaligned PC
      tbl[4] = '{pc:32'hBFC0_0013, instr:32'h0000_0000, daddr:32'h0, wdata:32'h0, rdata:32'h2222_2222,
                 drd:1'b0, dwr:1'b0, act:1'b1, fw:3, dw:0, faddr_exp:32'hBFC0_0010, daddr_exp:32'h0,
                 load_exp:32'hDEAD_BEEF, rd_exp:1'b0, wr_exp:1'b0, cycles_exp:6};
      // waits on both fetch and data read
      tbl[5] = '{pc:32'hBFC0_0014, instr:32'h8C46_0007, daddr:32'h0000_0007, wdata:32'h0, rdata:32'h0BAD_F00D,
                 drd:1'b1, dwr:1'b0, act:1'b1, fw:1, dw:3, faddr_exp:32'hBFC0_0014, daddr_exp:32'h0000_0004,
                 load_exp:32'h0BAD_F00D, rd_exp:1'b1, wr_exp:1'b0, cycles_exp:7};
      // core_active low before commit: commit pulse then HALT
      tbl[6] = '{pc:32'hBFC0_0018, instr:32'h0000_000D, daddr:32'h0, wdata:32'h0, rdata:32'h3333_3333,
                 drd:1'b0, dwr:1'b0, act:1'b0, fw:0, dw:0, faddr_exp:32'hBFC0_0018, daddr_exp:32'h0,
                 load_exp:32'h0BAD_F00D, rd_exp:1'b0, wr_exp:1'b0, cycles_exp:3};

      core_active         = 1'b1;
      core_instr_address  = 32'h0;
      core_data_address   = 32'h0;
      core_data_read      = 1'b0;
      core_data_write     = 1'b0;
      core_data_writedata = 32'h0;
      do_reset("reset_state");

      for (int i = 0; i < 7; i++) begin
         run_vec(tbl[i], i);
      end

      // HALT: no bus activity, inactive, latched words retained
      for (int c = 0; c < 4; c++) begin
         #1;
         check_cycle($sformatf("halt c%0d", c), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                     32'h0, 32'h0, last_instr, last_load);
         bus.waitrequest = (c == 1);
         @(negedge clk);
      end

      do_reset("reset_after_halt");
      run_vec(tbl[1], 1);

      // Reset while a data read is stalled
      core_instr_address = 32'hBFC0_0100;
      core_data_address  = 32'h0000_4000;
      core_data_read     = 1'b1;
      core_data_write    = 1'b0;
      core_active        = 1'b1;
      #1;
      check_cycle("rst_mid fetch", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'hBFC0_0100, 32'h0, last_instr, last_load);
      bus.waitrequest = 1'b0;
      bus.readdata    = 32'h8C46_0000;
      @(negedge clk);
      #1;
      check_cycle("rst_mid data", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_4000, 32'h0, 32'h8C46_0000, last_load);
      bus.waitrequest = 1'b1;
      bus.readdata    = JUNK;
      @(negedge clk);
      #1;
      check_cycle("rst_mid wait", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_4000, 32'h0, 32'h8C46_0000, last_load);
      reset = 1'b1;
      @(negedge clk);
      #1;
      check_cycle("rst_mid after", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
      reset           = 1'b0;
      bus.waitrequest = 1'b0;
      last_instr      = 32'h0;
      last_load       = 32'h0;
      @(negedge clk);

      // Stall timeout on fetch: four request cycles, then error and HALT
      core_instr_address = 32'hBFC0_0200;
      core_data_read     = 1'b0;
      bus.waitrequest    = 1'b1;
      for (int c = 0; c < 4; c++) begin
         #1;
         check_cycle($sformatf("timeout req c%0d", c), 1'b1, 1'b0, 1'b0, 1'b1, 1'b0,
                     32'hBFC0_0200, 32'h0, 32'h0, 32'h0);
         @(negedge clk);
      end
      for (int c = 0; c < 4; c++) begin
         #1;
         check_cycle($sformatf("timeout halt c%0d", c), 1'b0, 1'b0, 1'b0, 1'b0, 1'b1,
                     32'h0, 32'h0, 32'h0, 32'h0);
         bus.waitrequest = (c < 1);
         @(negedge clk);
      end
      do_reset("reset_clears_error");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
